// File: rtl/pan_luhn_stream.sv
// Streaming PAN checker: takes BCD digits one per cycle, keeps two running mod-10 Luhn sums
// (one per possible final-length parity), and hands out a frozen result over ready/valid.
module pan_luhn_stream #(
    parameter int MIN_LEN    = 12,
    parameter int MAX_LEN    = 19,
    parameter int IIN_DIGITS = 6,
    parameter int LEN_W      = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    digit_valid,
    input  logic [3:0]              digit_in,
    input  logic                    pan_end,
    output logic                    busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic                    res_luhn_ok,
    output logic                    res_len_ok,
    output logic [LEN_W-1:0]        res_len,
    output logic [4*IIN_DIGITS-1:0] res_iin,
    output logic [3:0]              res_check_digit,
    output logic                    err_bad_digit,
    output logic                    err_overflow
);

    // Handshake: a result transfers on a rising edge where res_valid && res_ready;
    // res_valid never drops without that transfer except on start or rst.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);

    state_t                  state, state_nxt;
    logic [LEN_W-1:0]        len, len_nxt;
    logic [3:0]              sum_e, sum_e_nxt;
    logic [3:0]              sum_o, sum_o_nxt;
    logic [3:0]              last_digit, last_digit_nxt;
    logic [4*IIN_DIGITS-1:0] iin, iin_nxt;
    logic                    bad, bad_nxt;
    logic                    ovf, ovf_nxt;
    logic                    accept;
    logic                    load_res;
    logic [3:0]              d_plain, d_dbl, sel_sum;
    logic                    len_ok_nxt, luhn_ok_nxt;

    function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    function automatic logic [3:0] luhn_dbl(input logic [3:0] d);
        logic [4:0] t;
        t = {d, 1'b0};
        if (d >= 4'd5) begin
            t = t - 5'd9;
        end
        return t[3:0];
    endfunction

    // Out-of-range digits feed both sums as d mod 10; luhn_ok is forced low for them anyway.
    always_comb begin
        if (digit_in > 4'd9) begin
            d_plain = digit_in - 4'd10;
            d_dbl   = digit_in - 4'd10;
        end else begin
            d_plain = digit_in;
            d_dbl   = luhn_dbl(digit_in);
        end
    end

    always_comb begin
        state_nxt      = state;
        len_nxt        = len;
        sum_e_nxt      = sum_e;
        sum_o_nxt      = sum_o;
        last_digit_nxt = last_digit;
        iin_nxt        = iin;
        bad_nxt        = bad;
        ovf_nxt        = ovf;
        load_res       = 1'b0;

        if (start) begin
            len_nxt        = '0;
            sum_e_nxt      = '0;
            sum_o_nxt      = '0;
            last_digit_nxt = '0;
            iin_nxt        = '0;
            bad_nxt        = 1'b0;
            ovf_nxt        = 1'b0;
        end

        // A digit alongside start is index 0 of the new PAN.
        accept = digit_valid && (start || (state == COLLECT));

        if (accept) begin
            if (len_nxt == MAX_L) begin
                ovf_nxt = 1'b1;
            end else begin
                if (digit_in > 4'd9) begin
                    bad_nxt = 1'b1;
                end
                if (len_nxt[0]) begin
                    sum_e_nxt = add_mod10(sum_e_nxt, d_plain);
                    sum_o_nxt = add_mod10(sum_o_nxt, d_dbl);
                end else begin
                    sum_e_nxt = add_mod10(sum_e_nxt, d_dbl);
                    sum_o_nxt = add_mod10(sum_o_nxt, d_plain);
                end
                for (int k = 0; k < IIN_DIGITS; k++) begin
                    if (int'(len_nxt) == IIN_DIGITS - 1 - k) begin
                        iin_nxt[4*k +: 4] = digit_in;
                    end
                end
                last_digit_nxt = digit_in;
                len_nxt        = len_nxt + 1'b1;
            end
        end

        if (start) begin
            state_nxt = COLLECT;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                COLLECT: begin
                    if (pan_end) begin
                        state_nxt = RESULT;
                        load_res  = 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Even final length checks the sum that doubled even indices, odd length the other one.
    always_comb begin
        sel_sum     = len_nxt[0] ? sum_o_nxt : sum_e_nxt;
        len_ok_nxt  = (len_nxt >= MIN_L) && (len_nxt <= MAX_L);
        luhn_ok_nxt = len_ok_nxt && !bad_nxt && !ovf_nxt && (sel_sum == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            len        <= '0;
            sum_e      <= '0;
            sum_o      <= '0;
            last_digit <= '0;
            iin        <= '0;
            bad        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            sum_e      <= sum_e_nxt;
            sum_o      <= sum_o_nxt;
            last_digit <= last_digit_nxt;
            iin        <= iin_nxt;
            bad        <= bad_nxt;
            ovf        <= ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_luhn_ok     <= 1'b0;
            res_len_ok      <= 1'b0;
            res_len         <= '0;
            res_iin         <= '0;
            res_check_digit <= '0;
            err_bad_digit   <= 1'b0;
            err_overflow    <= 1'b0;
        end else if (load_res) begin
            res_luhn_ok     <= luhn_ok_nxt;
            res_len_ok      <= len_ok_nxt;
            res_len         <= len_nxt;
            res_iin         <= iin_nxt;
            res_check_digit <= last_digit_nxt;
            err_bad_digit   <= bad_nxt;
            err_overflow    <= ovf_nxt;
        end
    end

    assign busy      = (state == COLLECT);
    assign res_valid = (state == RESULT);

endmodule
